// File: rtl/period_meter_if.sv
// Measurement bus for period_meter: slow input and clear pulse in, period/high-time results out.
// The slave modport is the meter itself; the master modport is whoever drives the input and reads results.
interface period_meter_if #(
    parameter int WIDTH = 32
);
    logic             sig_in;
    logic             ovf_clr;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             overflow;

    modport master (
        output sig_in, ovf_clr,
        input  period, high_time, period_valid, overflow
    );

    modport slave (
        input  sig_in, ovf_clr,
        output period, high_time, period_valid, overflow
    );
endinterface

// File: rtl/period_meter.sv
// Recovers period and high time of a slow asynchronous signal in clockin cycles.
// Define PERIOD_METER_DUTY_EN to build the high-time counter; otherwise high_time is tied to zero.
module period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clockin,
    input  logic          reset_n,
    period_meter_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        STALLED    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_prev_r;
    logic                   s_sync_s;
    logic                   rise_s;
    state_t                 state_r, state_s;
    logic [WIDTH-1:0]       count_r, count_s;
    logic [WIDTH-1:0]       period_r, period_s;
    logic                   valid_r, valid_s;
    logic                   ovf_r, ovf_s;
    logic                   load_s;
    logic                   inc_s;

    assign s_sync_s = sync_r[SYNC_STAGES-1];
    assign rise_s   = s_sync_s & ~s_prev_r;

    // Input synchroniser chain plus the edge-detect delay flop.
    always_ff @(posedge clockin) begin
        if (!reset_n) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            s_prev_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], bus.sig_in};
            s_prev_r <= s_sync_s;
        end
    end

    // Next-state, counter control and result capture; a rise only publishes from MEASURE.
    always_comb begin
        state_s  = state_r;
        period_s = period_r;
        valid_s  = 1'b0;
        ovf_s    = ovf_r & ~bus.ovf_clr;
        load_s   = 1'b0;
        inc_s    = 1'b0;
        case (state_r)
            WAIT_FIRST, STALLED: begin
                if (rise_s) begin
                    load_s  = 1'b1;
                    state_s = MEASURE;
                end else begin
                    state_s = state_r;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    load_s   = 1'b1;
                    period_s = count_r;
                    valid_s  = 1'b1;
                end else if (count_r == CNT_MAX) begin
                    // Saturate instead of wrapping; the set overrides a same-cycle clear.
                    state_s = STALLED;
                    ovf_s   = 1'b1;
                end else begin
                    inc_s = 1'b1;
                end
            end
            default: begin
                state_s = WAIT_FIRST;
            end
        endcase
        if (load_s) begin
            count_s = CNT_ONE;
        end else if (inc_s) begin
            count_s = count_r + CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // State, period counter and registered outputs.
    always_ff @(posedge clockin) begin
        if (!reset_n) begin
            state_r  <= WAIT_FIRST;
            count_r  <= CNT_ZERO;
            period_r <= CNT_ZERO;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            period_r <= period_s;
            valid_r  <= valid_s;
            ovf_r    <= ovf_s;
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [WIDTH-1:0] hcount_r, hcount_s;
    logic [WIDTH-1:0] high_r, high_s;

    // High-time counter follows the period counter's load/increment decisions.
    always_comb begin
        hcount_s = hcount_r;
        high_s   = high_r;
        if (load_s) begin
            hcount_s = CNT_ONE;
        end else if (inc_s && s_sync_s) begin
            hcount_s = hcount_r + CNT_ONE;
        end else begin
            hcount_s = hcount_r;
        end
        if (valid_s) begin
            high_s = hcount_r;
        end else begin
            high_s = high_r;
        end
    end

    // High-time counter and published high time.
    always_ff @(posedge clockin) begin
        if (!reset_n) begin
            hcount_r <= CNT_ZERO;
            high_r   <= CNT_ZERO;
        end else begin
            hcount_r <= hcount_s;
            high_r   <= high_s;
        end
    end

    assign bus.high_time = high_r;
`else
    assign bus.high_time = CNT_ZERO;
`endif

    assign bus.period       = period_r;
    assign bus.period_valid = valid_r;
    assign bus.overflow     = ovf_r;
endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (WIDTH=16, SYNC_STAGES=2) with hand-computed expectations.
module tb_period_meter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   strobe_cnt;
    int   b2b_cnt;
    logic prev_valid;
    logic [W-1:0] cap_period;
    logic [W-1:0] cap_high;
    logic [3:0]   lat_pat;
    logic         pre_ovf;
    int           first_ovf;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clockin (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_high(input logic [31:0] h);
`ifdef PERIOD_METER_DUTY_EN
        return h;
`else
        return 32'd0 & h;
`endif
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1 ns after the edge; tracks strobes and back-to-back strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.period_valid === 1'b1) begin
            strobe_cnt++;
            cap_period = bus.period;
            cap_high   = bus.high_time;
            if (prev_valid) b2b_cnt++;
        end
        prev_valid = bus.period_valid;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        strobe_cnt = 0;
        b2b_cnt    = 0;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            bus.sig_in = 1'b1;
            ticks(hi);
            bus.sig_in = 1'b0;
            ticks(lo);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.sig_in  = 1'b0;
        bus.ovf_clr = 1'b0;
        prev_valid  = 1'b0;
        cap_period  = 16'd0;
        cap_high    = 16'd0;
        clear_mon();
        ticks(3);
        check_vec("rst_period", 32'(bus.period), 32'd0);
        check_vec("rst_high", 32'(bus.high_time), 32'd0);
        check_vec("rst_valid", 32'(bus.period_valid), 32'd0);
        check_vec("rst_ovf", 32'(bus.overflow), 32'd0);
        reset_n = 1'b1;
        ticks(5);

        // Square wave 100 cycles, 30 high.
        wave(30, 70, 1);
        check_vec("first_rise_no_strobe", 32'(strobe_cnt), 32'd0);
        wave(30, 70, 4);
        check_vec("sq_strobes", 32'(strobe_cnt), 32'd4);
        check_vec("sq_b2b", 32'(b2b_cnt), 32'd0);
        check_vec("sq_period", 32'(cap_period), 32'd100);
        check_vec("sq_high", 32'(cap_high), exp_high(32'd30));

        // Latency: input changes after edge e, sampled at edge e+1.
        bus.sig_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            lat_pat[i] = bus.period_valid;
        end
        check_vec("latency_pattern", 32'(lat_pat), 32'd4);
        check_vec("latency_period", 32'(bus.period), 32'd100);
        ticks(10);
        bus.sig_in = 1'b0;
        ticks(5);

        // Minimum period: 2 cycles, 1 high.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            bus.sig_in = 1'b1;
            tick();
            bus.sig_in = 1'b0;
            tick();
        end
        ticks(5);
        check_vec("p2_strobes", 32'(strobe_cnt), 32'd10);
        check_vec("p2_b2b", 32'(b2b_cnt), 32'd0);
        check_vec("p2_period", 32'(cap_period), 32'd2);
        check_vec("p2_high", 32'(cap_high), exp_high(32'd1));

        // Overflow with ovf_clr held through saturation: set must win.
        clear_mon();
        first_ovf   = 0;
        pre_ovf     = 1'b1;
        bus.ovf_clr = 1'b1;
        bus.sig_in  = 1'b1;
        for (int n = 1; n <= 70000; n++) begin
            tick();
            if (n == 5) bus.sig_in = 1'b0;
            if (n == 10) clear_mon();
            if (n == 65537) pre_ovf = bus.overflow;
            if (bus.overflow === 1'b1 && first_ovf == 0) begin
                first_ovf   = n;
                bus.ovf_clr = 1'b0;
            end
        end
        bus.ovf_clr = 1'b0;
        check_vec("ovf_before_sat", 32'(pre_ovf), 32'd0);
        check_vec("ovf_first_cycle", 32'(first_ovf), 32'd65538);
        check_vec("ovf_sticky", 32'(bus.overflow), 32'd1);
        check_vec("ovf_no_strobe", 32'(strobe_cnt), 32'd0);

        // Recovery from STALLED: first rise only re-arms.
        clear_mon();
        wave(10, 40, 2);
        check_vec("stall_strobes", 32'(strobe_cnt), 32'd1);
        check_vec("stall_period", 32'(cap_period), 32'd50);
        check_vec("stall_high", 32'(cap_high), exp_high(32'd10));
        check_vec("ovf_held", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check_vec("ovf_clr", 32'(bus.overflow), 32'd0);

        // Reset in the middle of a measurement.
        ticks(15);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_vec("mid_rst_period", 32'(bus.period), 32'd0);
        check_vec("mid_rst_high", 32'(bus.high_time), 32'd0);
        check_vec("mid_rst_valid", 32'(bus.period_valid), 32'd0);
        ticks(5);
        clear_mon();
        wave(20, 60, 2);
        check_vec("post_rst_strobes", 32'(strobe_cnt), 32'd1);
        check_vec("post_rst_period", 32'(cap_period), 32'd80);
        check_vec("post_rst_high", 32'(cap_high), exp_high(32'd20));

        // Constant-high input after reset.
        bus.sig_in = 1'b1;
        reset_n    = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_mon();
        ticks(200);
        check_vec("const_hi_strobes", 32'(strobe_cnt), 32'd0);
        check_vec("const_hi_ovf", 32'(bus.overflow), 32'd0);
        check_vec("const_hi_period", 32'(bus.period), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
